// File: rtl/reg_10bit_we.sv
// Purpose : WIDTH-bit storage cell with write enable and async active-low clear (one register-file entry).
// Latency : one rising clk edge from (wen=1, d) to q; rst=0 clears q immediately.
// Backpres: none; a write is accepted on every enabled edge, and wen=0 simply holds the stored value.
module reg_10bit_we #(
   parameter int unsigned           WIDTH       = 10,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             wen,
   output logic [WIDTH-1:0] q
);

   // Storage flops and their next-state value; nothing else holds state.
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next state: load d when enabled, otherwise recirculate the stored value.
   always_comb begin
      q_d = q_q;
      if (wen) begin
         q_d = d;
      end
   end

   // Capture on the rising edge; reset wins over any write and needs no clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   // q comes straight off the flops, so d and wen have no combinational path to it.
   assign q = q_q;

endmodule

// File: tb/tb_reg_10bit_we.sv
// Purpose : directed check of reg_10bit_we: reset, write, hold, boundary values, between-edge changes, reset priority.
// Latency : expected values are queued by the stimulus and compared by an independent monitor process.
// Backpres: not applicable; stimulus waits for the monitor to drain each expectation before moving on.
module tb_reg_10bit_we;

    localparam int W = 10;

    logic         clk;
    logic         rst;
    logic [W-1:0] d;
    logic         wen;
    logic [W-1:0] q;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    reg_10bit_we #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .wen (wen),
        .q   (q)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: whenever an expectation is queued, sample q and compare.
    initial begin
        forever begin
            wait (exp_q.size() != 0);
            total++;
            if (q !== exp_q[0]) begin
                bad++;
                $display("FAIL %s: q=0x%03h expected 0x%03h", name_q[0], q, exp_q[0]);
            end
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "timeout");
    end

    // Queue an expectation and let the monitor consume it.
    task automatic expect_q(input string nm, input logic [W-1:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
        wait (exp_q.size() == 0);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled write followed by a check of the stored value.
    task automatic write_chk(input string nm, input logic [W-1:0] v);
        wen = 1'b1;
        d   = v;
        tick();
        expect_q(nm, v);
    endtask

    logic [W-1:0] bvals [4];

    initial begin
        rst = 1'b0;
        wen = 1'b0;
        d   = '0;
        #1;
        expect_q("reset_initial", 10'h000);

        // Release mid-cycle; an edge with wen=0 keeps the reset value.
        #2 rst = 1'b1;
        tick();
        expect_q("release_no_wen", 10'h000);

        // Load 0x2AB, then assert reset mid-cycle.
        write_chk("write_2ab", 10'h2AB);
        wen = 1'b0;
        #2 rst = 1'b0;
        #1;
        expect_q("async_clear_midcycle", 10'h000);
        total++;
        if (q !== 10'h000) begin
            bad++;
            $display("FAIL direct_async_clear: q=0x%03h expected 0x000", q);
        end

        // Reset held: enabled edges with all-ones data are ignored.
        wen = 1'b1;
        d   = 10'h3FF;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_q($sformatf("reset_hold_edge%0d", i), 10'h000);
        end

        // Release, then basic writes.
        wen = 1'b0;
        #2 rst = 1'b1;
        tick();
        write_chk("write_155", 10'h155);
        write_chk("write_2aa", 10'h2AA);

        // Hold with d toggling.
        wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = (i % 2 == 0) ? 10'h000 : 10'h3FF;
            tick();
            expect_q($sformatf("hold_edge%0d", i), 10'h2AA);
        end

        // Boundary values, bit-exact.
        bvals[0] = 10'h3FF;
        bvals[1] = 10'h000;
        bvals[2] = 10'h001;
        bvals[3] = 10'h200;
        for (int i = 0; i < 4; i++) begin
            write_chk($sformatf("boundary_%03h", bvals[i]), bvals[i]);
        end

        // Between edges: only the value present at the edge is taken.
        wen = 1'b1;
        d   = 10'h123;
        #1;
        expect_q("between_edges_a", 10'h200);
        #3 d = 10'h321;
        #1;
        expect_q("between_edges_b", 10'h200);
        tick();
        expect_q("between_edges_capture", 10'h321);

        // Reset coincident with an enabled edge: reset wins.
        wen = 1'b1;
        d   = 10'h0F0;
        @(posedge clk);
        rst = 1'b0;
        #1;
        expect_q("reset_priority", 10'h000);
        total++;
        if (q !== 10'h000) begin
            bad++;
            $display("FAIL direct_reset_priority: q=0x%03h expected 0x000", q);
        end

        // Release does not change q; next enabled edge loads d.
        wen = 1'b0;
        #3 rst = 1'b1;
        #1;
        expect_q("release_no_change", 10'h000);
        total++;
        if (q !== 10'h000) begin
            bad++;
            $display("FAIL direct_release_no_change: q=0x%03h expected 0x000", q);
        end
        tick();
        expect_q("release_then_hold", 10'h000);
        write_chk("release_then_write", 10'h0F0);
        total++;
        if (q !== 10'h0F0) begin
            bad++;
            $display("FAIL direct_release_then_write: q=0x%03h expected 0x0f0", q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        if (bad != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $finish;
    end

endmodule

// File: doc/reg_10bit_we.md
Name: reg_10bit_we

Overview:
- Single-clock, 10-bit storage register with write enable and asynchronous active-low clear.
- Used as the per-register storage cell in the 8-entry register file (s0..s3, t0, t1, ra, sp).
- Instantiated eight times, sharing d, clk and rst, with a one-hot wen per instance.
- q is read combinationally by the register-file read multiplexers.

Parameters:
- WIDTH, 10, data width of d and q.
- RESET_VALUE, 0 (WIDTH bits), value loaded into q while rst is asserted.

Ports:
- clk  input  1  clock; all captures occur on the rising edge.
- rst  input  1  reset, asynchronous, active-low; rst=0 forces q to RESET_VALUE immediately.
- d  input  WIDTH  write data.
- wen  input  1  write enable, active-high, sampled on the rising edge of clk.
- q  output  WIDTH  stored value, driven directly from the storage flops with no output logic.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, on port rst.
- Reset:
  - Falling edge of rst, or rst held low: q = RESET_VALUE (0x000) at once, without waiting for clk.
  - While rst=0, clock edges and wen are ignored.
- Reset release:
  - rst 0->1 does not change q.
  - The first rising clk edge with rst=1 and wen=1 performs a normal capture.
- Write: rising clk edge with rst=1 and wen=1 -> q takes d as sampled at that edge. Latency is one edge: the new value is visible right after the edge.
- Hold: rising clk edge with rst=1 and wen=0 -> q unchanged.
- Changes on d or wen between clock edges have no effect on q.
- Priority: reset over write. If rst=0 coincides with a clk edge that has wen=1, q = RESET_VALUE.
- Width rules:
  - d is stored bit-exact with no arithmetic, sign handling or truncation.
  - All values 0x000..0x3FF are storable.
- Power-up before any reset: q is undefined. The system asserts rst before use.
- Structure: no internal state other than the WIDTH storage flops, and no combinational path from d or wen to q.
- Glitch-free q: q changes only on a rising clk edge (capture) or on rst assertion.

Test Plan:
- Reset: drive rst=0 mid-cycle with q=0x2AB -> q=0x000 within the same time step, before the next clk edge. Hold rst=0 with wen=1, d=0x3FF for 3 edges -> q stays 0x000.
- Basic write: rst=1, wen=1, d=0x155, one rising edge -> q=0x155. Then d=0x2AA, wen=1, one edge -> q=0x2AA.
- Hold: q=0x2AA, wen=0, d toggled 0x000/0x3FF across 4 edges -> q remains 0x2AA.
- Boundary values: write 0x3FF -> q=0x3FF, then write 0x000 -> q=0x000, then write 0x001 and 0x200 -> q matches exactly with no bit loss.
- Between edges: set wen=1 and d=0x123 after a rising edge, then change d to 0x321 before the next edge -> q=0x321 after that edge, and q is unchanged between edges.
- Reset release and priority: assert rst=0 coincident with a clk edge carrying wen=1, d=0x0F0 -> q=0x000. Release rst -> q still 0x000 until the next enabled edge, which loads d.
